// File: rtl/sched_pkg.sv
// sched_pkg: shared constants and state type for the ball scheduler
package sched_pkg;
    localparam int MAX_BALLS = 7;
    localparam int TIME_W = 9;
    localparam int HEIGHT_W = 4;
    typedef enum logic [1:0] {IDLE, RUN, THROW} state_t;
endpackage

// File: rtl/ball_scheduler_minimum.sv
// minimum: index and value of the smallest of the first max entries, lowest index wins ties
module minimum #(
    parameter int N = 7,
    parameter int W = 9
) (
    input  logic [W-1:0] values [N],
    input  logic [2:0]   max,
    output logic [2:0]   index,
    output logic [W-1:0] value
);
    // linear scan; with max=0 the result stays index 0, value all-ones
    always_comb begin
        index = '0;
        value = '1;
        for (int i = 0; i < N; i++) begin
            if (3'(i) < max && values[i] < value) begin
                index = 3'(i);
                value = values[i];
            end
        end
    end
endmodule

// File: rtl/ball_scheduler.sv
// ball_scheduler: siteswap juggling scheduler tracking per-ball remaining beats
// Optional macro SCHED_STATS_EN adds the throw_count_out successful-throw counter.
module ball_scheduler #(
    parameter int TIME_W = sched_pkg::TIME_W,
    parameter int HEIGHT_W = sched_pkg::HEIGHT_W
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                start_in,
    input  logic [2:0]          num_balls_in,
    input  logic                beat_in,
    input  logic                throw_valid_in,
    input  logic [HEIGHT_W-1:0] throw_height_in,
    output logic                throw_ready_out,
    output logic                ball_valid_out,
    output logic [2:0]          ball_index_out,
    output logic [TIME_W-1:0]   ball_time_out,
    output logic                error_out,
    output logic                busy_out
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0]         throw_count_out
`endif
);
    import sched_pkg::*;

    state_t            state, state_nxt;
    logic [2:0]        n;
    logic [TIME_W-1:0] rem [MAX_BALLS];
    logic [TIME_W-1:0] rem_nxt [MAX_BALLS];
    logic [2:0]        k;
    logic [TIME_W-1:0] k_val;
    logic              accept, hit, err_nxt;
    logic [3:0]        zeros;

    minimum #(.N(MAX_BALLS), .W(TIME_W)) u_min (
        .values(rem),
        .max(n),
        .index(k),
        .value(k_val)
    );

    assign accept = state == THROW && throw_valid_in;
    assign hit = accept && k_val == '0 && throw_height_in != '0;
    assign throw_ready_out = state == THROW;
    assign busy_out = state != IDLE;

    // start wins everywhere; a beat only matters in RUN; an accepted throw returns to RUN
    always_comb begin
        state_nxt = start_in ? RUN : (state == RUN && beat_in) ? THROW : accept ? RUN : state;
    end

    // candidate counters after a throw, plus drop/phantom/collision detection
    always_comb begin
        zeros = '0;
        for (int i = 0; i < MAX_BALLS; i++) begin
            rem_nxt[i] = rem[i];
            if (3'(i) < n) begin
                rem_nxt[i] = (hit && 3'(i) == k) ? TIME_W'(throw_height_in - 1'b1)
                           : (rem[i] == '0) ? '0 : rem[i] - 1'b1;
                zeros = zeros + ((rem_nxt[i] == '0) ? 4'd1 : 4'd0);
            end
        end
        err_nxt = accept && (((k_val == '0) == (throw_height_in == '0)) || zeros > 4'd1);
    end

    // state register
    always_ff @(posedge clk_in) begin
        if (!rst_in) state <= IDLE;
        else state <= state_nxt;
    end

    // ball counters, report outputs and sticky error
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            n <= '0;
            for (int i = 0; i < MAX_BALLS; i++) rem[i] <= '1;
            ball_valid_out <= 1'b0;
            ball_index_out <= '0;
            ball_time_out <= '0;
            error_out <= 1'b0;
        end else begin
            ball_valid_out <= 1'b0;
            if (start_in) begin
                n <= num_balls_in;
                for (int i = 0; i < MAX_BALLS; i++) rem[i] <= (3'(i) < num_balls_in) ? TIME_W'(i) : '1;
                error_out <= 1'b0;
            end else if (accept) begin
                for (int i = 0; i < MAX_BALLS; i++) rem[i] <= rem_nxt[i];
                error_out <= error_out | err_nxt;
                if (hit) begin
                    ball_valid_out <= 1'b1;
                    ball_index_out <= k;
                    ball_time_out <= TIME_W'(throw_height_in - 1'b1);
                end
            end
        end
    end

`ifdef SCHED_STATS_EN
    // successful-throw counter, wraps naturally at 16 bits
    always_ff @(posedge clk_in) begin
        if (!rst_in || start_in) throw_count_out <= '0;
        else if (hit) throw_count_out <= throw_count_out + 16'd1;
    end
`endif
endmodule

// File: tb/tb_ball_scheduler.sv
// tb_ball_scheduler: table-driven self-checking bench for ball_scheduler
module tb_ball_scheduler;
    logic       clk = 1'b0;
    logic       rst_in = 1'b0;
    logic       start_in = 1'b0;
    logic [2:0] num_balls_in = '0;
    logic       beat_in = 1'b0;
    logic       throw_valid_in = 1'b0;
    logic [3:0] throw_height_in = '0;
    logic       throw_ready_out, ball_valid_out, error_out, busy_out;
    logic [2:0] ball_index_out;
    logic [8:0] ball_time_out;
`ifdef SCHED_STATS_EN
    logic [15:0] throw_count_out;
`endif
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       start;
        logic [2:0] n;
        logic [3:0] h;
        logic       v;
        logic [2:0] idx;
        logic [8:0] t;
        logic       err;
    } vec_t;
    vec_t vecs[$];

    ball_scheduler dut (
        .clk_in(clk),
        .rst_in(rst_in),
        .start_in(start_in),
        .num_balls_in(num_balls_in),
        .beat_in(beat_in),
        .throw_valid_in(throw_valid_in),
        .throw_height_in(throw_height_in),
        .throw_ready_out(throw_ready_out),
        .ball_valid_out(ball_valid_out),
        .ball_index_out(ball_index_out),
        .ball_time_out(ball_time_out),
        .error_out(error_out),
        .busy_out(busy_out)
`ifdef SCHED_STATS_EN
        ,
        .throw_count_out(throw_count_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic [2:0] n, input logic [3:0] h,
                       input logic v, input logic [2:0] idx, input logic [8:0] t, input logic e);
        vec_t x;
        x.start = s; x.n = n; x.h = h; x.v = v; x.idx = idx; x.t = t; x.err = e;
        vecs.push_back(x);
    endtask

    task automatic do_start(input logic [2:0] n);
        @(negedge clk);
        start_in = 1'b1;
        num_balls_in = n;
        @(negedge clk);
        start_in = 1'b0;
    endtask

    task automatic do_throw(input logic [3:0] h);
        @(negedge clk);
        chk("valid_one_cycle", ball_valid_out, 0);
        chk("ready_in_run", throw_ready_out, 0);
        beat_in = 1'b1;
        @(negedge clk);
        beat_in = 1'b0;
        chk("ready_in_throw", throw_ready_out, 1);
        throw_valid_in = 1'b1;
        throw_height_in = h;
        @(negedge clk);
        throw_valid_in = 1'b0;
    endtask

    initial begin
        // n=3 cascade of 3s
        add(1, 3, 3, 1, 0, 2, 0);
        add(0, 3, 3, 1, 1, 2, 0);
        add(0, 3, 3, 1, 2, 2, 0);
        add(0, 3, 3, 1, 0, 2, 0);
        add(0, 3, 3, 1, 1, 2, 0);
        add(0, 3, 3, 1, 2, 2, 0);
        add(0, 3, 3, 1, 0, 2, 0);
        add(0, 3, 3, 1, 1, 2, 0);
        // n=3 pattern 441
        add(1, 3, 4, 1, 0, 3, 0);
        add(0, 3, 4, 1, 1, 3, 0);
        add(0, 3, 1, 1, 2, 0, 0);
        add(0, 3, 4, 1, 2, 3, 0);
        add(0, 3, 4, 1, 0, 3, 0);
        add(0, 3, 1, 1, 1, 0, 0);
        // drop, sticky error, start clears it
        add(1, 3, 0, 0, 0, 0, 1);
        add(0, 3, 3, 1, 0, 2, 1);
        add(1, 3, 3, 1, 0, 2, 0);
        // n=2: drop onto a landing ball, phantom throw, empty-hand 0, collision
        add(1, 2, 2, 1, 0, 1, 0);
        add(0, 2, 0, 0, 0, 0, 1);
        add(1, 2, 3, 1, 0, 2, 0);
        add(0, 2, 3, 1, 1, 2, 0);
        add(0, 2, 3, 0, 0, 0, 1);
        add(1, 2, 3, 1, 0, 2, 0);
        add(0, 2, 3, 1, 1, 2, 0);
        add(0, 2, 0, 0, 0, 0, 0);
        add(0, 2, 1, 1, 0, 0, 1);
        // n=0: no ball ever selected
        add(1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 1);
        // n=7 upper bound
        add(1, 7, 7, 1, 0, 6, 0);
        add(0, 7, 7, 1, 1, 6, 0);

        repeat (3) @(negedge clk);
        chk("rst_busy", busy_out, 0);
        chk("rst_ready", throw_ready_out, 0);
        chk("rst_valid", ball_valid_out, 0);
        chk("rst_index", ball_index_out, 0);
        chk("rst_time", ball_time_out, 0);
        chk("rst_error", error_out, 0);
        rst_in = 1'b1;

        foreach (vecs[j]) begin
            if (vecs[j].start) do_start(vecs[j].n);
            do_throw(vecs[j].h);
            chk($sformatf("v%0d_error", j), error_out, vecs[j].err);
            chk($sformatf("v%0d_valid", j), ball_valid_out, vecs[j].v);
            if (vecs[j].v) begin
                chk($sformatf("v%0d_index", j), ball_index_out, vecs[j].idx);
                chk($sformatf("v%0d_time", j), ball_time_out, vecs[j].t);
            end
        end

        // reset during THROW with a throw offered and the error flag set
        do_start(3);
        do_throw(0);
        chk("pre_rst_error", error_out, 1);
        @(negedge clk);
        beat_in = 1'b1;
        @(negedge clk);
        beat_in = 1'b0;
        chk("pre_rst_ready", throw_ready_out, 1);
        throw_valid_in = 1'b1;
        throw_height_in = 4'd3;
        rst_in = 1'b0;
        @(negedge clk);
        rst_in = 1'b1;
        throw_valid_in = 1'b0;
        chk("midrst_busy", busy_out, 0);
        chk("midrst_ready", throw_ready_out, 0);
        chk("midrst_valid", ball_valid_out, 0);
        chk("midrst_error", error_out, 0);
        chk("midrst_index", ball_index_out, 0);
        chk("midrst_time", ball_time_out, 0);
        @(negedge clk);
        chk("midrst_valid_later", ball_valid_out, 0);
        // beat in IDLE is ignored
        beat_in = 1'b1;
        @(negedge clk);
        beat_in = 1'b0;
        chk("idle_beat_busy", busy_out, 0);
        chk("idle_beat_ready", throw_ready_out, 0);
        @(negedge clk);
        chk("idle_beat_ready2", throw_ready_out, 0);
        chk("idle_beat_valid", ball_valid_out, 0);

`ifdef SCHED_STATS_EN
        chk("count_after_rst", throw_count_out, 0);
        do_start(1);
        repeat (5) do_throw(1);
        chk("count_five", throw_count_out, 5);
        do_throw(0);
        chk("count_no_incr", throw_count_out, 5);
        do_start(1);
        chk("count_start_clear", throw_count_out, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
